// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin packet arbiter sharing one uart_tx between requesters
module uart_tx_arbiter #(
    parameter int  N_REQ    = 4,
    parameter int  WORD     = 8,
    parameter int  HDR_EN   = 1,
    parameter int  HDR_BASE = 'hA0,
    parameter int  TIMEOUT  = 65535,
    localparam int GW       = $clog2(N_REQ)
) (
    input  logic                  i_Clock,
    input  logic                  i_Rst_n,
    input  logic [N_REQ-1:0]      i_Req_Valid,
    input  logic [N_REQ*WORD-1:0] i_Req_Data,
    input  logic [N_REQ-1:0]      i_Req_Last,
    output logic [N_REQ-1:0]      o_Req_Ready,
    output logic                  o_Uart_DV,
    output logic [WORD-1:0]       o_Uart_Byte,
    input  logic                  i_Uart_Active,
    input  logic                  i_Uart_Done,
    output logic [GW-1:0]         o_Grant_Id,
    output logic                  o_Busy,
    output logic                  o_Pkt_Done,
    output logic                  o_Abort
);

    // Counter only needs to reach TIMEOUT-1; the abort fires on that value.
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HDR   = 3'd1,
        S_FETCH = 3'd2,
        S_SEND  = 3'd3,
        S_WAIT  = 3'd4
    } state_t;

    state_t             r_state;
    logic [GW-1:0]      r_grant;
    logic [GW-1:0]      r_last_grant;
    logic [N_REQ-1:0]   r_ready;
    logic               r_dv;
    logic [WORD-1:0]    r_byte;
    logic               r_is_last;
    logic               r_pkt_done;
    logic               r_abort;
    logic               r_done_q;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_any_valid;
    logic [GW-1:0]      w_pick;
    logic               w_done_rise;
    logic               w_uart_free;

    // Round-robin pick: lowest offset from last_grant+1 with valid wins, so scan
    // offsets from the far end down and let the nearest one overwrite.
    always_comb begin
        w_any_valid = |i_Req_Valid;
        w_pick      = '0;
        for (int i = N_REQ; i >= 1; i--) begin
            if (i_Req_Valid[(int'(r_last_grant) + i) % N_REQ]) begin
                w_pick = GW'((int'(r_last_grant) + i) % N_REQ);
            end
        end
    end

    // Done may last two cycles: only its rising edge ends a byte, and a load is
    // safe once the line is idle or done is already in its second cycle.
    assign w_done_rise = i_Uart_Done & ~r_done_q;
    assign w_uart_free = (~i_Uart_Active & ~i_Uart_Done) | (i_Uart_Done & r_done_q);

    // Packet sequencing FSM with registered strobes and ready.
    always_ff @(posedge i_Clock) begin
        if (!i_Rst_n) begin
            r_state      <= S_IDLE;
            r_grant      <= '0;
            r_last_grant <= GW'(N_REQ - 1);
            r_ready      <= '0;
            r_dv         <= 1'b0;
            r_byte       <= '0;
            r_is_last    <= 1'b0;
            r_pkt_done   <= 1'b0;
            r_abort      <= 1'b0;
            r_done_q     <= 1'b0;
            r_cnt        <= '0;
        end else begin
            r_done_q   <= i_Uart_Done;
            r_dv       <= 1'b0;
            r_pkt_done <= 1'b0;
            r_abort    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any_valid) begin
                        r_grant <= w_pick;
                        if (HDR_EN != 0) begin
                            r_state <= S_HDR;
                        end else begin
                            r_state <= S_FETCH;
                            r_ready <= N_REQ'(1) << w_pick;
                            r_cnt   <= '0;
                        end
                    end
                end
                S_HDR: begin
                    r_byte    <= WORD'(HDR_BASE) | WORD'(r_grant);
                    r_is_last <= 1'b0;
                    r_state   <= S_SEND;
                end
                S_FETCH: begin
                    if (i_Req_Valid[r_grant]) begin
                        r_byte    <= i_Req_Data[int'(r_grant)*WORD +: WORD];
                        r_is_last <= i_Req_Last[r_grant];
                        r_ready   <= '0;
                        r_state   <= S_SEND;
                    end else if (TIMEOUT != 0 && r_cnt == CNT_W'(TIMEOUT - 1)) begin
                        r_abort      <= 1'b1;
                        r_last_grant <= r_grant;
                        r_ready      <= '0;
                        r_state      <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_SEND: begin
                    if (w_uart_free) begin
                        r_dv    <= 1'b1;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (w_done_rise) begin
                        if (r_is_last) begin
                            r_pkt_done   <= 1'b1;
                            r_last_grant <= r_grant;
                            r_state      <= S_IDLE;
                        end else begin
                            r_ready <= N_REQ'(1) << r_grant;
                            r_cnt   <= '0;
                            r_state <= S_FETCH;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= '0;
                end
            endcase
        end
    end

    assign o_Req_Ready = r_ready;
    assign o_Uart_DV   = r_dv;
    assign o_Uart_Byte = r_byte;
    assign o_Grant_Id  = r_grant;
    assign o_Busy      = (r_state != S_IDLE);
    assign o_Pkt_Done  = r_pkt_done;
    assign o_Abort     = r_abort;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - scoreboard bench for uart_tx_arbiter with a behavioural uart_tx
module tb_uart_tx_arbiter;

    localparam int N         = 4;
    localparam int W         = 8;
    localparam int HDR_EN    = 1;
    localparam int HDR_BASE  = 'hA0;
    localparam int TO        = 100;
    localparam int BIT_TICKS = 40;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req_valid, req_last, ready;
    logic [N*W-1:0] req_data;
    logic           dv, active, done, busy, pkt_done, abort_p;
    logic [W-1:0]   ubyte;
    logic [1:0]     gid;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .N_REQ(N), .WORD(W), .HDR_EN(HDR_EN), .HDR_BASE(HDR_BASE), .TIMEOUT(TO)
    ) dut (
        .i_Clock(clk), .i_Rst_n(rst_n),
        .i_Req_Valid(req_valid), .i_Req_Data(req_data), .i_Req_Last(req_last),
        .o_Req_Ready(ready), .o_Uart_DV(dv), .o_Uart_Byte(ubyte),
        .i_Uart_Active(active), .i_Uart_Done(done),
        .o_Grant_Id(gid), .o_Busy(busy), .o_Pkt_Done(pkt_done), .o_Abort(abort_p)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_q[$];
    int         gid_q[$];

    logic [8:0] rbuf [N][0:63];
    int head[N], tail[N], stall[N], big_stall[N];

    int pk_k[$], pk_st[$], pk_len[$];
    int m_last = N - 1;
    bit expect_abort = 1'b0;
    int line_cnt = 0;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, req, req);
        end
    endtask

    // Requester drivers: present queued bytes, advance on handshake, insert
    // bubbles only inside a packet so arbitration always sees pending packets.
    initial begin
        logic [N-1:0] hs;
        req_valid = '0; req_data = '0; req_last = '0;
        for (int k = 0; k < N; k++) begin
            head[k] = 0; tail[k] = 0; stall[k] = 0; big_stall[k] = 0;
        end
        forever begin
            @(negedge clk);
            hs = req_valid & ready;
            @(posedge clk); #1;
            for (int k = 0; k < N; k++) begin
                if (hs[k]) begin
                    if (!rbuf[k][head[k]][8]) begin
                        if (big_stall[k] > 0) begin
                            stall[k] = big_stall[k];
                            big_stall[k] = 0;
                        end else if ($urandom_range(0, 3) == 0) begin
                            stall[k] = $urandom_range(1, 8);
                        end
                    end
                    head[k]++;
                end else if (stall[k] > 0) begin
                    stall[k]--;
                end
                req_valid[k] = (head[k] < tail[k]) && (stall[k] == 0);
                req_data[k*W +: W] = rbuf[k][head[k]][7:0];
                req_last[k] = rbuf[k][head[k]][8];
            end
        end
    end

    // Behavioural uart_tx and line monitor: each accepted byte is popped from
    // the scoreboard; done lasts one or two cycles at random.
    initial begin
        int busy_cnt, done_cnt;
        logic [7:0] cur;
        bit cur_ok;
        busy_cnt = 0; done_cnt = 0; cur = '0; cur_ok = 1'b0;
        active = 1'b0; done = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (!rst_n) cur_ok = 1'b0;
            if (done_cnt > 0) done_cnt--;
            if (dv) begin
                chk("uart_free_at_dv", int'(active), 0);
                if (!active) begin
                    line_cnt++;
                    if (exp_q.size() == 0) chk("line_unexpected", int'(ubyte), -1);
                    else chk("line_byte", int'(ubyte), int'(exp_q.pop_front()));
                    cur = ubyte; cur_ok = 1'b1;
                    active = 1'b1; busy_cnt = BIT_TICKS;
                end
            end else if (active) begin
                if (cur_ok) chk("byte_held", int'(ubyte), int'(cur));
                busy_cnt--;
                if (busy_cnt == 0) begin
                    active = 1'b0;
                    done_cnt = $urandom_range(1, 2);
                end
            end
            done = (done_cnt > 0);
        end
    end

    // Event monitor: packet completion grant, unexpected aborts, one-hot ready.
    initial begin
        forever begin
            @(negedge clk);
            chk("ready_onehot", int'($countones(ready) <= 1), 1);
            if (pkt_done) begin
                if (gid_q.size() == 0) chk("pkt_done_unexpected", 1, 0);
                else chk("pkt_grant", int'(gid), gid_q.pop_front());
            end
            if (abort_p) chk("abort_expected", int'(expect_abort), 1);
        end
    end

    task automatic start_phase();
        for (int k = 0; k < N; k++) begin
            head[k] = 0; tail[k] = 0;
        end
    endtask

    task automatic add_pkt(input int k, input int len, input bit last_flag);
        pk_k.push_back(k);
        pk_st.push_back(tail[k]);
        pk_len.push_back(len);
        for (int i = 0; i < len; i++) begin
            rbuf[k][tail[k]] = {(i == len - 1) && last_flag, 8'($urandom)};
            tail[k]++;
        end
    endtask

    // Reference: whole packets served round-robin from the requester after the
    // previous grantee, each requester's packets in load order.
    task automatic run_model();
        bit served[$];
        bit found;
        int c;
        foreach (pk_k[i]) served.push_back(1'b0);
        do begin
            found = 1'b0;
            for (int off = 1; off <= N && !found; off++) begin
                c = (m_last + off) % N;
                foreach (pk_k[i]) begin
                    if (!found && !served[i] && pk_k[i] == c) begin
                        found = 1'b1;
                        served[i] = 1'b1;
                        if (HDR_EN != 0) exp_q.push_back(8'(HDR_BASE | c));
                        for (int b = 0; b < pk_len[i]; b++)
                            exp_q.push_back(rbuf[c][pk_st[i] + b][7:0]);
                        gid_q.push_back(c);
                        m_last = c;
                    end
                end
            end
        end while (found);
        pk_k.delete(); pk_st.delete(); pk_len.delete();
    endtask

    task automatic wait_idle();
        bit ok;
        bit drained;
        ok = 1'b0;
        for (int n = 0; n < 6000 && !ok; n++) begin
            @(negedge clk);
            drained = 1'b1;
            for (int k = 0; k < N; k++) if (head[k] < tail[k]) drained = 1'b0;
            if (!busy && !active && drained && exp_q.size() == 0) ok = 1'b1;
        end
        if (!ok) chk("idle_timeout", 0, 1);
    endtask

    task automatic random_phase();
        start_phase();
        for (int k = 0; k < N; k++) begin
            int np;
            np = $urandom_range(0, 2);
            for (int p = 0; p < np; p++) add_pkt(k, $urandom_range(1, 5), 1'b1);
        end
        run_model();
        wait_idle();
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_ready"}, int'(ready), 0);
        chk({tag, "_dv"}, int'(dv), 0);
        chk({tag, "_byte"}, int'(ubyte), 0);
        chk({tag, "_gid"}, int'(gid), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_pkt_done"}, int'(pkt_done), 0);
        chk({tag, "_abort"}, int'(abort_p), 0);
    endtask

    initial begin
        int n_rdy, base;
        bit seen;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst_n = 1'b1;

        // All four requesters, single-byte packets, twice: order 0,1,2,3 each time.
        for (int r = 0; r < 2; r++) begin
            start_phase();
            for (int k = 0; k < N; k++) add_pkt(k, 1, 1'b1);
            run_model();
            wait_idle();
        end

        for (int r = 0; r < 6; r++) random_phase();

        // Requester 2 stalls mid-packet with requester 0 waiting.
        start_phase();
        add_pkt(1, 1, 1'b1);
        run_model();
        wait_idle();
        start_phase();
        big_stall[2] = 100;
        add_pkt(2, 3, 1'b1);
        add_pkt(0, 1, 1'b1);
        run_model();
        seen = 1'b0;
        for (int n = 0; n < 2000 && !seen; n++) begin
            @(negedge clk);
            if (stall[2] > 0 && stall[2] <= 20) seen = 1'b1;
        end
        chk("stall_reached", int'(seen), 1);
        chk("stall_gid", int'(gid), 2);
        chk("stall_ready", int'(ready), 4);
        chk("stall_busy", int'(busy), 1);
        wait_idle();

        // Requester 3 stops after one byte: abort after TO cycles of ready.
        start_phase();
        add_pkt(3, 1, 1'b0);
        pk_k.delete(); pk_st.delete(); pk_len.delete();
        exp_q.push_back(8'(HDR_BASE | 3));
        exp_q.push_back(rbuf[3][0][7:0]);
        m_last = 3;
        expect_abort = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 500 && !seen; n++) begin
            @(negedge clk);
            if (exp_q.size() == 0) seen = 1'b1;
        end
        chk("timeout_bytes_sent", int'(seen), 1);
        n_rdy = 0; seen = 1'b0;
        for (int n = 0; n < 400 && !seen; n++) begin
            @(negedge clk);
            if (ready[3]) n_rdy++;
            if (abort_p) seen = 1'b1;
        end
        chk("abort_seen", int'(seen), 1);
        chk("timeout_ready_cycles", n_rdy, TO);
        chk("abort_idle", int'(busy), 0);
        @(negedge clk);
        chk("abort_width", int'(abort_p), 0);
        expect_abort = 1'b0;
        start_phase();
        add_pkt(1, 2, 1'b1);
        add_pkt(0, 2, 1'b1);
        run_model();
        wait_idle();

        // Reset while the second data byte is on the line.
        start_phase();
        add_pkt(1, 3, 1'b1);
        run_model();
        base = line_cnt;
        seen = 1'b0;
        for (int n = 0; n < 1000 && !seen; n++) begin
            @(negedge clk);
            if (line_cnt == base + 3) seen = 1'b1;
        end
        chk("reset_reach_byte2", int'(seen), 1);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        for (int k = 0; k < N; k++) begin
            head[k] = 0; tail[k] = 0; stall[k] = 0;
        end
        exp_q.delete(); gid_q.delete();
        m_last = N - 1;
        @(negedge clk);
        check_outputs_zero("midreset");
        rst_n = 1'b1;
        start_phase();
        add_pkt(2, 2, 1'b1);
        run_model();
        wait_idle();

        random_phase();
        random_phase();

        chk("exp_bytes_left", exp_q.size(), 0);
        chk("exp_pkts_left", gid_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
